core_ifu: RTL



---
 rtl/core_ifu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/core_ifu.sv
// core_ifu: in-order instruction fetch unit with a DEPTH-entry reservation
// FIFO, arbitrary-latency responses and redirect flush of in-flight fetches.
module core_ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INST_WIDTH-1:0] ifu_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [INST_WIDTH-1:0] inst_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] epc_d [DEPTH];
  logic [INST_WIDTH-1:0] edat_q [DEPTH];
  logic [INST_WIDTH-1:0] edat_d [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q, fill_ptr_d;
  ptr_t head_ptr_q, head_ptr_d;
  cnt_t alloc_cnt_q, alloc_cnt_d;
  cnt_t drop_cnt_q, drop_cnt_d;

  cnt_t n_filled;
  sum_t inflight;
  logic req_fire;
  logic deq;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  always_comb begin
    n_filled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_filled = n_filled + cnt_t'(filled_q[i]);
    end
  end

  assign inflight = sum_t'(alloc_cnt_q) + sum_t'(drop_cnt_q);

  assign ifu_req_valid = !rst && !redirect_valid &&
                         (inflight < sum_t'(DEPTH));
  assign ifu_addr = pc_q;

  assign inst_valid = !rst && !redirect_valid &&
                      filled_q[head_ptr_q] && (alloc_cnt_q != '0);
  assign inst_pc   = epc_q[head_ptr_q];
  assign inst_data = edat_q[head_ptr_q];

  assign req_fire = ifu_req_valid && ifu_req_ready;
  assign deq      = inst_valid && inst_ready;

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    edat_d      = edat_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (redirect_valid) begin
      pc_d        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      alloc_cnt_d = '0;
      // unfilled entries still owe a response; one arriving now is consumed
      drop_cnt_d  = drop_cnt_q + (alloc_cnt_q - n_filled)
                    - cnt_t'(ifu_rsp_valid);
    end else begin
      if (req_fire) begin
        epc_d[alloc_ptr_q]    = pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + ptr_t'(1);
        pc_d                  = pc_q + ADDR_WIDTH'(4);
      end
      if (ifu_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - cnt_t'(1);
        end else begin
          edat_d[fill_ptr_q]   = ifu_data;
          filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d           = fill_ptr_q + ptr_t'(1);
        end
      end
      if (deq) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + ptr_t'(1);
      end
      alloc_cnt_d = alloc_cnt_q + cnt_t'(req_fire) - cnt_t'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // payload storage is qualified by filled_q, so it needs no reset
  always_ff @(posedge clk) begin
    epc_q  <= epc_d;
    edat_q <= edat_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ifu_rsp_valid && alloc_cnt_q == '0 && drop_cnt_q == '0));
    end
  end

endmodule
